// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - shared opcode/func codes, state and pc_src encodings
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_SLL, F_SRL, F_SRA, F_JR, F_ADD, F_ADDU, F_SUB,
          F_SUBU, F_AND, F_OR, F_NOR, F_SLT, F_SLTU: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_LL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles, flags the last allowed one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // High in the wait cycle that would bring the count up to MEM_TIMEOUT.
  assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle MIPS control sequencer with shared memory port
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             link,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             fault
);

  state_t cur_state;
  state_t nxt_state;
  logic   retire;
  logic   set_illegal;
  logic   set_fault;
  logic   wait_en;
  logic   expired;
  logic   is_jr;

  assign is_jr = (opcode == OP_RTYPE) && (func == F_JR);
  assign state = cur_state;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!wait_en),
    .en     (wait_en),
    .expired(expired)
  );

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SEQ;
    reg_write   = 1'b0;
    link        = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    wait_en     = 1'b0;
    nxt_state   = cur_state;

    case (cur_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_SEQ;
          nxt_state = ST_DECODE;
        end else begin
          wait_en = 1'b1;
          if (expired) begin
            set_fault = 1'b1;
            nxt_state = ST_TRAP;
          end
        end
      end
      ST_DECODE: begin
        if (!is_legal(opcode, func)) begin
          set_illegal = 1'b1;
          nxt_state   = ST_TRAP;
        end else if (opcode == OP_J) begin
          pc_write  = 1'b1;
          pc_src    = PC_JUMP;
          retire    = 1'b1;
          nxt_state = ST_FETCH;
        end else if (opcode == OP_JAL) begin
          nxt_state = ST_WB;
        end else begin
          nxt_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (opcode == OP_BEQ || opcode == OP_BNE) begin
          pc_write  = (opcode == OP_BEQ) ? zero : !zero;
          pc_src    = PC_BRANCH;
          retire    = 1'b1;
          nxt_state = ST_FETCH;
        end else if (is_jr) begin
          pc_write  = 1'b1;
          pc_src    = PC_REG;
          retire    = 1'b1;
          nxt_state = ST_FETCH;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          nxt_state = ST_MEM;
        end else begin
          nxt_state = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire    = 1'b1;
            nxt_state = ST_FETCH;
          end else begin
            nxt_state = ST_WB;
          end
        end else begin
          wait_en = 1'b1;
          if (expired) begin
            set_fault = 1'b1;
            nxt_state = ST_TRAP;
          end
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        if (opcode == OP_JAL) begin
          link     = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        retire    = 1'b1;
        nxt_state = ST_FETCH;
      end
      ST_TRAP: nxt_state = ST_TRAP;
      default: nxt_state = ST_TRAP;
    endcase

    // Reset abandons any in-flight access: no strobe may escape this cycle.
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SEQ;
      reg_write   = 1'b0;
      link        = 1'b0;
      retire      = 1'b0;
      set_illegal = 1'b0;
      set_fault   = 1'b0;
      wait_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= ST_FETCH;
      retired   <= '0;
      illegal   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (retire) retired <= retired + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_fault) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized self-checking bench with instruction-level model
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam int P_FW = 0;
  localparam int P_FR = 1;
  localparam int P_D  = 2;
  localparam int P_E  = 3;
  localparam int P_MW = 4;
  localparam int P_MR = 5;
  localparam int P_W  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    func = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, pc_write, reg_write, link;
  logic [1:0]    pc_src;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic          illegal, fault;
  logic [11:0]   act;
  logic [CW-1:0] exp_ret = '0;
  int            checks = 0;
  int            errors = 0;

  logic [5:0] legal_ops [14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h04,
                                 6'h05, 6'h30, 6'h0F, 6'h23, 6'h0D, 6'h0A, 6'h0B};
  logic [5:0] legal_fns [13] = '{6'h20, 6'h21, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                                 6'h00, 6'h02, 6'h03, 6'h22, 6'h23, 6'h08};

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .link(link), .state(state), .retired(retired),
    .illegal(illegal), .fault(fault)
  );

  assign act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, link};

  // Expected outputs for one cycle of an instruction, derived from its phase.
  function automatic logic [11:0] expect_vec(input int ph, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z);
    logic [2:0] st = 3'd0;
    logic req = 1'b0, we = 1'b0, ad = 1'b0, irw = 1'b0, pcw = 1'b0, rw = 1'b0, lk = 1'b0;
    logic [1:0] src = 2'd0;
    case (ph)
      P_FW: begin st = 3'd0; req = 1'b1; end
      P_FR: begin st = 3'd0; req = 1'b1; irw = 1'b1; pcw = 1'b1; end
      P_D: begin
        st = 3'd1;
        if (op == 6'h02) begin pcw = 1'b1; src = 2'd2; end
      end
      P_E: begin
        st = 3'd2;
        if (op == 6'h04) begin pcw = z; src = 2'd1; end
        if (op == 6'h05) begin pcw = !z; src = 2'd1; end
        if (op == 6'h00 && fn == 6'h08) begin pcw = 1'b1; src = 2'd3; end
      end
      P_MW, P_MR: begin st = 3'd3; req = 1'b1; ad = 1'b1; we = (op == 6'h2B); end
      P_W: begin
        st = 3'd4; rw = 1'b1;
        if (op == 6'h03) begin lk = 1'b1; pcw = 1'b1; src = 2'd2; end
      end
      default: st = 3'd7;
    endcase
    return {st, req, we, ad, irw, pcw, src, rw, lk};
  endfunction

  task automatic step(input int ph, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input bit last);
    logic [11:0] e;
    @(negedge clk);
    opcode    = (ph == P_FW || ph == P_FR) ? 6'($urandom) : op;
    func      = (ph == P_FW || ph == P_FR) ? 6'($urandom) : fn;
    zero      = (ph == P_E) ? z : 1'($urandom);
    mem_ready = (ph == P_FW || ph == P_MW) ? 1'b0 :
                (ph == P_FR || ph == P_MR) ? 1'b1 : 1'($urandom);
    #1;
    e = expect_vec(ph, op, fn, z);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL step ph=%0d op=%h fn=%h: outputs %h required %h", ph, op, fn, act, e);
    end
    checks++;
    if (retired !== exp_ret) begin
      errors++;
      $display("FAIL retired ph=%0d op=%h: got %0d required %0d", ph, op, retired, exp_ret);
    end
    checks++;
    if ({illegal, fault} !== 2'b00) begin
      errors++;
      $display("FAIL flags ph=%0d: illegal/fault %b required 00", ph, {illegal, fault});
    end
    if (last) exp_ret = exp_ret + CW'(1);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    int ph[$];
    repeat (fw) ph.push_back(P_FW);
    ph.push_back(P_FR);
    ph.push_back(P_D);
    if (op == 6'h03) begin
      ph.push_back(P_W);
    end else if (op != 6'h02) begin
      ph.push_back(P_E);
      if (!(op == 6'h04 || op == 6'h05 || (op == 6'h00 && fn == 6'h08))) begin
        if (op == 6'h23 || op == 6'h2B) begin
          repeat (mw) ph.push_back(P_MW);
          ph.push_back(P_MR);
        end
        if (op != 6'h2B) ph.push_back(P_W);
      end
    end
    foreach (ph[i]) step(ph[i], op, fn, z, i == ph.size() - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (act[8:0] !== 9'b0) begin
      errors++;
      $display("FAIL reset_strobes: strobes %b required 0", act[8:0]);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({state, retired, illegal, fault} !== {3'd0, {CW{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: state %0d retired %0d illegal %b fault %b required 0",
               state, retired, illegal, fault);
    end
    checks++;
    if (act[8:0] !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold: strobes %b required 0", act[8:0]);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(6'h23, 6'h00, 1'b0, 3, 2);
  endtask

  task automatic test_branches();
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 1, 0);
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_jal();
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      op = legal_ops[$urandom_range(0, 13)];
      fn = (op == 6'h00) ? legal_fns[$urandom_range(0, 12)] : 6'($urandom);
      run_instr(op, fn, 1'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TO) step(P_FW, 6'h00, 6'h20, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      #1;
      checks++;
      if (act !== {3'd7, 9'b0}) begin
        errors++;
        $display("FAIL timeout_trap c=%0d: outputs %h required %h", c, act, {3'd7, 9'b0});
      end
      checks++;
      if ({illegal, fault, retired} !== {2'b01, exp_ret}) begin
        errors++;
        $display("FAIL timeout_flags: illegal %b fault %b retired %0d required 0 1 %0d",
                 illegal, fault, retired, exp_ret);
      end
    end
    do_reset();
    run_instr(6'h00, 6'h21, 1'b0, TO - 1, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 0, TO - 1);
    step(P_FR, 6'h00, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    logic [5:0] bad_op [2] = '{6'h3F, 6'h00};
    logic [5:0] bad_fn [2] = '{6'h00, 6'h01};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      run_instr(6'h00, 6'h20, 1'b0, 0, 0);
      step(P_FR, 6'h00, 6'h00, 1'b0, 1'b0);
      step(P_D, bad_op[k], bad_fn[k], 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        mem_ready = 1'($urandom);
        zero = 1'($urandom);
        #1;
        checks++;
        if (act !== {3'd7, 9'b0}) begin
          errors++;
          $display("FAIL illegal_trap k=%0d c=%0d: outputs %h required %h", k, c, act, {3'd7, 9'b0});
        end
        checks++;
        if ({illegal, fault, retired} !== {2'b10, exp_ret}) begin
          errors++;
          $display("FAIL illegal_flags k=%0d: illegal %b fault %b retired %0d required 1 0 %0d",
                   k, illegal, fault, retired, exp_ret);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    step(P_FR, 6'h2B, 6'h00, 1'b0, 1'b0);
    step(P_D, 6'h2B, 6'h00, 1'b0, 1'b0);
    step(P_E, 6'h2B, 6'h00, 1'b0, 1'b0);
    step(P_MW, 6'h2B, 6'h00, 1'b0, 1'b0);
    do_reset();
    run_instr(6'h2B, 6'h00, 1'b0, 1, 1);
    step(P_FR, 6'h00, 6'h00, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_jal();
    test_random();
    test_timeout();
    test_illegal();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- FSM that turns the single-cycle MIPS datapath into a multi-cycle machine sharing one memory port for instruction fetch and data access.
- Sequences the FETCH/DECODE/EXEC/MEM/WB steps and issues the write strobes for the PC, IR, memory and register file.
- Sits beside the opcode/func decoder, which still supplies ALU op and mux selects; this block only decides when each strobe fires.
- Adds a memory wait handshake with timeout, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before a fault (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- opcode  in  6  instr[31:26] from IR, valid from DECODE onward.
- func  in  6  instr[5:0] from IR.
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req (sw only).
- iord  out  1  0 = address from PC, 1 = address from ALU result.
- ir_write  out  1  latch instruction into IR.
- pc_write  out  1  load PC.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- reg_write  out  1  register-file write strobe.
- link  out  1  force write of PC+4 to $31 (jal).
- state  out  3  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.
- illegal  out  1  sticky; unknown opcode/func trapped.
- fault  out  1  sticky; memory timeout trapped.

Behaviour:
- Reset (rst_n=0 at posedge): state=FETCH, wait counter=0, retired=0, illegal=0, fault=0. Every strobe is forced to 0 while rst_n=0. Reset mid-access abandons the access with no strobe.
- Strobes are Moore/Mealy combinational from state, opcode, func, zero and mem_ready. Counters and sticky flags are registered.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - mem_req=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - j: pc_write=1, pc_src=2; retire; next FETCH.
  - jal: next WB.
  - Unknown opcode, or R-type with unsupported func: next TRAP, set illegal.
  - All others: next EXEC.
  - Legal set: R-type func {20,21,24,25,27,2A,2B,00,02,03,22,23,08}; opcodes {02,03,08,09,0C,04,05,30,0F,23,0D,0A,0B,2B}.
- EXEC:
  - beq: pc_write=zero, pc_src=1; retire; next FETCH.
  - bne: pc_write=!zero, pc_src=1; retire; next FETCH.
  - jr: pc_write=1, pc_src=3; retire; next FETCH.
  - lw/sw: next MEM.
  - Everything else: next WB.
- MEM:
  - mem_req=1, iord=1, mem_we=(opcode==sw).
  - On mem_ready: sw retires and goes to FETCH; lw goes to WB.
- WB:
  - reg_write=1.
  - jal: link=1, pc_write=1, pc_src=2.
  - Retire; next FETCH.
- Memory handshake:
  - mem_req stays high until mem_ready is sampled high; the request drops in the following cycle.
  - mem_ready outside FETCH/MEM is ignored.
  - The wait counter clears on entering FETCH/MEM and increments each non-ready cycle.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: next TRAP, set fault. mem_ready on that same cycle wins, so there is no fault.
- TRAP: all strobes 0; exit only via reset.
- Retire: retired increments by 1 in the cycle the instruction completes, wrapping modulo 2^CNT_W.
- Zero-wait latencies:
  - j: 2 cycles.
  - beq/bne/jr/jal: 3 cycles.
  - ALU-type and sw: 4 cycles.
  - lw: 5 cycles.

Decomposition:
- Shared package holds:
  - opcode and func localparams (shared with the decoder);
  - state encoding;
  - pc_src encoding.
- One natural sub-module, mem_wait_timer: counter with clear, enable and MEM_TIMEOUT compare, output expired.

Test Plan:
- add (opcode 00, func 20), mem_ready always 1 -> states 0,1,2,4,0; reg_write high 1 cycle at cycle 4; retired=1.
- lw, mem_ready delayed 3 cycles in FETCH and 2 in MEM -> FETCH held 4 cycles with mem_req=1; MEM iord=1, mem_we=0; total 10 cycles; reg_write in WB.
- beq with zero=1 then bne with zero=1 -> pc_write=1/pc_src=1 for beq; pc_write=0 for bne; both retire in 3 cycles.
- jal -> DECODE then WB with reg_write=1, link=1, pc_write=1, pc_src=2. Opcode 3F -> TRAP, illegal=1, no strobes thereafter, retired unchanged.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> TRAP after 4 wait cycles, fault=1. Repeat with mem_ready on the 4th cycle -> DECODE, fault=0.
- rst_n low during MEM of sw -> mem_req and mem_we drop in the reset cycle; after release, state=FETCH, retired=0, flags clear.
